// File: rtl/data_mem_responder.sv
// Data-memory responder for the pipeline MEM stage.
// Takes one load/store at a time through a valid/ready handshake and checks size and alignment.
// It writes or reads the addressed byte lanes and returns a one-cycle response LATENCY edges after accept.
// Storage is split into four byte-lane arrays so that partial stores need no read-modify-write.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_write,
    input  logic [1:0]  i_req_size,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_resp_valid,
    output logic [31:0] o_resp_rdata,
    output logic        o_resp_err,
    output logic        o_stall
);

    localparam int AW = $clog2(DEPTH_WORDS);

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_cnt;

    // Request captured on the accepting edge
    logic        r_write;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;

    // Response-side registers, updated on the edge entering RESP
    logic        r_rsp_load;
    logic [1:0]  r_rsp_size;
    logic [1:0]  r_rsp_off;
    logic        r_resp_err;

    logic        w_accept;
    logic        w_enter_resp;
    logic        w_cur_write;
    logic [1:0]  w_cur_size;
    logic [31:0] w_cur_addr;
    logic [31:0] w_cur_wdata;
    logic        w_err;
    logic        w_commit;
    logic        w_load;
    logic [AW-1:0] w_idx;
    logic [3:0]  w_be;
    logic [31:0] w_wdata_rep;
    logic [31:0] w_rd_word;
    logic        w_unused_addr_bits;

    // State register; reset drops any outstanding request
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        w_state_next = r_state;
        o_req_ready  = 1'b0;
        o_resp_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_req_ready = i_rst_n;
                if (i_req_valid && i_rst_n) begin
                    w_state_next = (LATENCY == 1) ? ST_RESP : ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (r_cnt <= 4'd1) begin
                    w_state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                o_resp_valid = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign w_accept     = i_req_valid && o_req_ready;
    assign w_enter_resp = (r_state != ST_RESP) && (w_state_next == ST_RESP);
    assign o_stall      = i_req_valid && !o_req_ready;

    // Latency counter and request capture
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt   <= '0;
            r_write <= 1'b0;
            r_size  <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_cnt   <= 4'(LATENCY - 1);
            r_write <= i_req_write;
            r_size  <= i_req_size;
            r_addr  <= i_req_addr;
            r_wdata <= i_req_wdata;
        end else if (r_state == ST_BUSY) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // With LATENCY=1 the accepting edge is also the RESP-entering edge, so the
    // live inputs are used while idle and the captured copy otherwise.
    assign w_cur_write = (r_state == ST_IDLE) ? i_req_write : r_write;
    assign w_cur_size  = (r_state == ST_IDLE) ? i_req_size  : r_size;
    assign w_cur_addr  = (r_state == ST_IDLE) ? i_req_addr  : r_addr;
    assign w_cur_wdata = (r_state == ST_IDLE) ? i_req_wdata : r_wdata;

    assign w_idx              = w_cur_addr[2 +: AW];
    assign w_unused_addr_bits = ^w_cur_addr[31:AW+2];

    // Alignment and size legality, byte enables and lane-replicated write data
    always_comb begin
        w_err       = 1'b0;
        w_be        = 4'b0000;
        w_wdata_rep = w_cur_wdata;
        case (w_cur_size)
            SZ_WORD: begin
                w_err       = (w_cur_addr[1:0] != 2'b00);
                w_be        = 4'b1111;
                w_wdata_rep = w_cur_wdata;
            end
            SZ_HALF: begin
                w_err       = w_cur_addr[0];
                w_be        = w_cur_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata_rep = {2{w_cur_wdata[15:0]}};
            end
            SZ_BYTE: begin
                w_err       = 1'b0;
                w_be        = 4'b0001 << w_cur_addr[1:0];
                w_wdata_rep = {4{w_cur_wdata[7:0]}};
            end
            default: begin
                w_err = 1'b1;
            end
        endcase
    end

    assign w_commit = w_enter_resp && w_cur_write && !w_err;
    assign w_load   = w_enter_resp && !w_cur_write && !w_err;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] r_mem [DEPTH_WORDS];
            logic [7:0] r_rd;

            // One byte lane: enabled write, registered read
            always_ff @(posedge i_clk) begin
                if (w_commit && w_be[gi]) begin
                    r_mem[w_idx] <= w_wdata_rep[8*gi +: 8];
                end
                if (w_load) begin
                    r_rd <= r_mem[w_idx];
                end
            end

            assign w_rd_word[8*gi +: 8] = r_rd;
        end
    endgenerate

    // Response qualifiers held until the next RESP-entering edge
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rsp_load <= 1'b0;
            r_rsp_size <= '0;
            r_rsp_off  <= '0;
            r_resp_err <= 1'b0;
        end else if (w_enter_resp) begin
            r_rsp_load <= !w_cur_write && !w_err;
            r_rsp_size <= w_cur_size;
            r_rsp_off  <= w_cur_addr[1:0];
            r_resp_err <= w_err;
        end
    end

    assign o_resp_err = r_resp_err;

    // Right-justify and zero-extend the addressed lanes; zero for stores and errors
    always_comb begin
        o_resp_rdata = '0;
        if (r_rsp_load) begin
            case (r_rsp_size)
                SZ_WORD: o_resp_rdata = w_rd_word;
                SZ_HALF: o_resp_rdata = {16'h0000, (r_rsp_off[1] ? w_rd_word[31:16] : w_rd_word[15:0])};
                SZ_BYTE: begin
                    case (r_rsp_off)
                        2'd0:    o_resp_rdata = {24'h000000, w_rd_word[7:0]};
                        2'd1:    o_resp_rdata = {24'h000000, w_rd_word[15:8]};
                        2'd2:    o_resp_rdata = {24'h000000, w_rd_word[23:16]};
                        default: o_resp_rdata = {24'h000000, w_rd_word[31:24]};
                    endcase
                end
                default: o_resp_rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: dut0 runs at LATENCY=2, dut1 at LATENCY=1.
// Expected responses are queued at issue time and checked by a negedge monitor.
module tb_data_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [1:0]        valid, write, ready, rvalid, err, stall;
    logic [1:0][1:0]   size;
    logic [1:0][31:0]  addr, wdata, rdata;

    data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(valid[0]), .o_req_ready(ready[0]),
        .i_req_write(write[0]), .i_req_size(size[0]),
        .i_req_addr(addr[0]), .i_req_wdata(wdata[0]),
        .o_resp_valid(rvalid[0]), .o_resp_rdata(rdata[0]),
        .o_resp_err(err[0]), .o_stall(stall[0])
    );

    data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(valid[1]), .o_req_ready(ready[1]),
        .i_req_write(write[1]), .i_req_size(size[1]),
        .i_req_addr(addr[1]), .i_req_wdata(wdata[1]),
        .o_resp_valid(rvalid[1]), .o_resp_rdata(rdata[1]),
        .o_resp_err(err[1]), .o_stall(stall[1])
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
        string       name;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one request; queue its expected response when it is accepted.
    task automatic send(input int d, input string name, input logic w, input logic [1:0] s,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err, input bit hold,
                        output int acc_cyc, output int stalls);
        int   n;
        exp_t e;
        @(negedge clk);
        valid[d] = 1'b1; write[d] = w; size[d] = s; addr[d] = a; wdata[d] = wd;
        #1;
        stalls = 0;
        n = 0;
        while (!ready[d] && n < 50) begin
            if (stall[d]) stalls++;
            n++;
            @(negedge clk);
            #1;
        end
        acc_cyc = -1;
        if (n >= 50) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s: accept timeout, ready stayed %b expected 1", name, ready[d]);
            valid[d] = 1'b0;
        end else begin
            e.rdata = exp_rd;
            e.err   = exp_err;
            e.cyc   = cyc + lat(d);
            e.name  = name;
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
            acc_cyc = cyc + 1;
            @(posedge clk);
            #1;
            if (!hold) valid[d] = 1'b0;
            // Scramble request fields while busy; the DUT must ignore them
            write[d] = ~w;
            size[d]  = 2'($urandom_range(0, 3));
            addr[d]  = $urandom;
            wdata[d] = $urandom;
        end
    endtask

    task automatic take(input int d);
        exp_t e;
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            n_vec++;
            n_bad++;
            $display("FAIL dut%0d unexpected response: rvalid %b expected 0 (rdata %h)", d, rvalid[d], rdata[d]);
        end else begin
            e = (d == 0) ? q0.pop_front() : q1.pop_front();
            chk({e.name, " rdata"}, rdata[d], e.rdata);
            chk({e.name, " err"}, 32'(err[d]), 32'(e.err));
            chk({e.name, " resp cycle"}, cyc, e.cyc);
            $display("dut%0d %-22s rdata=%h err=%b cyc=%0d", d, e.name, rdata[d], err[d], cyc);
        end
    endtask

    // Monitor: every response strobe is matched against the scoreboard
    always @(negedge clk) begin
        if (rvalid[0]) take(0);
        if (rvalid[1]) take(1);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int a, s;
        int ac[4];
        int st[4];
        rst_n = 1'b1;
        valid = '0; write = '0; size = '0; addr = '0; wdata = '0;
        #2 rst_n = 1'b0;

        // Reset state, ready forced low and stall visible while in reset
        repeat (2) @(negedge clk);
        valid[0] = 1'b1;
        #1;
        chk("reset ready0", 32'(ready[0]), 32'd0);
        chk("reset ready1", 32'(ready[1]), 32'd0);
        chk("reset rvalid0", 32'(rvalid[0]), 32'd0);
        chk("reset rdata0", rdata[0], 32'd0);
        chk("reset err0", 32'(err[0]), 32'd0);
        chk("reset stall0", 32'(stall[0]), 32'd1);
        valid[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post-reset ready0", 32'(ready[0]), 32'd1);
        chk("post-reset ready1", 32'(ready[1]), 32'd1);

        // Word store/load and lane behaviour
        send(0, "st w DEADBEEF@10", 1, 2'b00, 32'h10, 32'hDEADBEEF, 32'h0, 0, 0, a, s);
        send(0, "ld w @10",         0, 2'b00, 32'h10, 32'h0, 32'hDEADBEEF, 0, 0, a, s);
        send(0, "st w 11223344@10", 1, 2'b00, 32'h10, 32'h11223344, 32'h0, 0, 0, a, s);
        send(0, "st b AA@13",       1, 2'b10, 32'h13, 32'hFFFFFFAA, 32'h0, 0, 0, a, s);
        send(0, "ld w @10 merged",  0, 2'b00, 32'h10, 32'h0, 32'hAA223344, 0, 0, a, s);
        send(0, "ld b @13",         0, 2'b10, 32'h13, 32'h0, 32'h000000AA, 0, 0, a, s);
        send(0, "ld h @12",         0, 2'b01, 32'h12, 32'h0, 32'h0000AA22, 0, 0, a, s);
        send(0, "ld b @10",         0, 2'b10, 32'h10, 32'h0, 32'h00000044, 0, 0, a, s);
        send(0, "ld h @10",         0, 2'b01, 32'h10, 32'h0, 32'h00003344, 0, 0, a, s);
        send(0, "st h 5566@10",     1, 2'b01, 32'h10, 32'h12345566, 32'h0, 0, 0, a, s);
        send(0, "ld w @10 half",    0, 2'b00, 32'h10, 32'h0, 32'hAA225566, 0, 0, a, s);

        // Misaligned and illegal-size requests are rejected and change nothing
        send(0, "ld h @11 misalign", 0, 2'b01, 32'h11, 32'h0, 32'h0, 1, 0, a, s);
        send(0, "st w @12 misalign", 1, 2'b00, 32'h12, 32'hFFFFFFFF, 32'h0, 1, 0, a, s);
        send(0, "ld size11 @10",     0, 2'b11, 32'h10, 32'h0, 32'h0, 1, 0, a, s);
        send(0, "st size11 @10",     1, 2'b11, 32'h10, 32'h0BADF00D, 32'h0, 1, 0, a, s);
        send(0, "ld w @10 unchanged", 0, 2'b00, 32'h10, 32'h0, 32'hAA225566, 0, 0, a, s);

        // Index wraps: upper address bits are ignored
        send(0, "st w CAFEF00D@1000", 1, 2'b00, 32'h1000, 32'hCAFEF00D, 32'h0, 0, 0, a, s);
        send(0, "ld w @0 wrap",       0, 2'b00, 32'h0, 32'h0, 32'hCAFEF00D, 0, 0, a, s);

        // Back-to-back with ReqValid held high at LATENCY=2
        send(0, "st w 0@30", 1, 2'b00, 32'h30, 32'h0, 32'h0, 0, 0, a, s);
        send(0, "b2b st b 77@31", 1, 2'b10, 32'h31, 32'h00000077, 32'h0, 0, 1, ac[0], st[0]);
        send(0, "b2b ld w @30",   0, 2'b00, 32'h30, 32'h0, 32'h00007700, 0, 1, ac[1], st[1]);
        send(0, "b2b ld h @30",   0, 2'b01, 32'h30, 32'h0, 32'h00007700, 0, 1, ac[2], st[2]);
        send(0, "b2b ld b @31",   0, 2'b10, 32'h31, 32'h0, 32'h00000077, 0, 0, ac[3], st[3]);
        for (int i = 1; i < 4; i++) begin
            chk($sformatf("dut0 b2b accept gap %0d", i), ac[i] - ac[i-1], 32'd3);
            // Stall spans the BUSY and RESP cycles of the previous request
            chk($sformatf("dut0 b2b stall cycles %0d", i), st[i], 32'd2);
        end

        // Back-to-back at LATENCY=1
        send(1, "L1 st w A5A5A5A5@4", 1, 2'b00, 32'h4, 32'hA5A5A5A5, 32'h0, 0, 1, ac[0], st[0]);
        send(1, "L1 st h BEEF@6",     1, 2'b01, 32'h6, 32'h0000BEEF, 32'h0, 0, 1, ac[1], st[1]);
        send(1, "L1 ld w @4",         0, 2'b00, 32'h4, 32'h0, 32'hBEEFA5A5, 0, 1, ac[2], st[2]);
        send(1, "L1 ld b @7",         0, 2'b10, 32'h7, 32'h0, 32'h000000BE, 0, 0, ac[3], st[3]);
        for (int i = 1; i < 4; i++) begin
            chk($sformatf("dut1 b2b accept gap %0d", i), ac[i] - ac[i-1], 32'd2);
            chk($sformatf("dut1 b2b stall cycles %0d", i), st[i], 32'd1);
        end
        send(1, "L1 ld h @5 misalign", 0, 2'b01, 32'h5, 32'h0, 32'h0, 1, 0, a, s);

        // Reset during BUSY drops a store
        send(0, "st w 01020304@20", 1, 2'b00, 32'h20, 32'h01020304, 32'h0, 0, 0, a, s);
        repeat (4) @(negedge clk);
        valid[0] = 1'b1; write[0] = 1'b1; size[0] = 2'b00; addr[0] = 32'h20; wdata[0] = 32'h99999999;
        #1;
        chk("pre-abort ready0", 32'(ready[0]), 32'd1);
        @(posedge clk);
        #1;
        valid[0] = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("abort ready0 in reset", 32'(ready[0]), 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("abort rvalid0 in reset", 32'(rvalid[0]), 32'd0);
        end
        rst_n = 1'b1;
        #1;
        chk("abort ready0 after reset", 32'(ready[0]), 32'd1);
        send(0, "ld w @20 after abort", 0, 2'b00, 32'h20, 32'h0, 32'h01020304, 0, 0, a, s);

        // Drain and confirm nothing was lost
        repeat (8) @(negedge clk);
        chk("dut0 queue drained", q0.size(), 32'd0);
        chk("dut1 queue drained", q1.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
